time_unit_counter: RTL and testbench

Parametrised modulo-(MAX+1) time-unit counter for the alarm-clock datapath. It serves as the generic seconds, minutes or hours stage. It advances on a carry-in pulse from the lower stage and supports user set-up and set-down adjustment plus a direct parallel load. It emits a single-cycle carry to the next stage on wrap, and provides registered two-digit BCD display outputs with optional 12-hour presentation.

---
 rtl/time_unit_counter.sv | 94 +++++++++
 tb/tb_time_unit_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_unit_counter.sv
// Modulo-(MAX+1) time-unit counter stage for the alarm-clock datapath.
// Counts on carry-in, supports user adjust and parallel load, and drives registered BCD display digits.
module time_unit_counter #(
    parameter int MAX    = 23,
    parameter int WIDTH  = 5,
    parameter int HOUR12 = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             set_up,
    input  logic             set_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode12,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             load_err,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             pm
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam bit USE12 = (HOUR12 == 1) && (MAX == 23);

    logic [6:0] raw_val;
    logic [6:0] disp_val;
    logic       pm_next;
    logic [3:0] tens_next;
    logic [3:0] ones_next;

    // Priority is load, then inc, then the user adjust; adjust wraps silently without carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_val > MAX_V) begin
                    load_err <= 1'b1;
                end else begin
                    count <= load_val;
                end
            end else if (inc) begin
                if (count == MAX_V) begin
                    count <= '0;
                    carry <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (set_up && !set_dn) begin
                count <= (count == MAX_V) ? '0 : count + 1'b1;
            end else if (set_dn && !set_up) begin
                count <= (count == '0) ? MAX_V : count - 1'b1;
            end
        end
    end

    always_comb begin
        raw_val  = 7'(count);
        disp_val = raw_val;
        pm_next  = 1'b0;
        if (USE12 && mode12) begin
            if (raw_val == 7'd0) begin
                disp_val = 7'd12;
            end else if (raw_val >= 7'd12) begin
                pm_next = 1'b1;
                if (raw_val > 7'd12) begin
                    disp_val = raw_val - 7'd12;
                end
            end
        end
        tens_next = 4'(disp_val / 7'd10);
        ones_next = 4'(disp_val % 7'd10);
    end

    // Display registers lag count by one edge so the divider sits in its own cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_tens <= 4'd0;
            bcd_ones <= 4'd0;
            pm       <= 1'b0;
        end else begin
            bcd_tens <= tens_next;
            bcd_ones <= ones_next;
            pm       <= pm_next;
        end
    end

endmodule

// File: tb/tb_time_unit_counter.sv
// Directed bench for time_unit_counter: hours instance (default) and a seconds-style MAX=59 instance.
module tb_time_unit_counter;

    logic       clk;
    logic       rst;
    logic       inc, set_up, set_dn, load, mode12;
    logic [4:0] load_val;
    logic [4:0] count;
    logic       carry, load_err, pm;
    logic [3:0] bcd_tens, bcd_ones;

    logic       b_inc, b_set_up, b_set_dn, b_load;
    logic [5:0] b_load_val;
    logic [5:0] b_count;
    logic       b_carry, b_load_err, b_pm;
    logic [3:0] b_tens, b_ones;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   prev_a   = 0;
    int   prev_b   = 0;

    time_unit_counter dut_a (
        .clk(clk), .rst(rst), .inc(inc), .set_up(set_up), .set_dn(set_dn),
        .load(load), .load_val(load_val), .mode12(mode12),
        .count(count), .carry(carry), .load_err(load_err),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .pm(pm)
    );

    time_unit_counter #(.MAX(59), .WIDTH(6), .HOUR12(0)) dut_b (
        .clk(clk), .rst(rst), .inc(b_inc), .set_up(b_set_up), .set_dn(b_set_dn),
        .load(b_load), .load_val(b_load_val), .mode12(mode12),
        .count(b_count), .carry(b_carry), .load_err(b_load_err),
        .bcd_tens(b_tens), .bcd_ones(b_ones), .pm(b_pm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:  return 32'(count);
            1:  return 32'(carry);
            2:  return 32'(load_err);
            3:  return 32'(bcd_tens);
            4:  return 32'(bcd_ones);
            5:  return 32'(pm);
            10: return 32'(b_count);
            11: return 32'(b_carry);
            12: return 32'(b_load_err);
            13: return 32'(b_tens);
            14: return 32'(b_ones);
            15: return 32'(b_pm);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = 32'(exp);
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_checks++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("[TB] FAIL %s (sel %0d): observed %0d expected %0d", e.tag, e.sel, obs, e.exp);
            end
        end
    endtask

    // Expected display for a count value, following the 12/24-hour presentation rules.
    task automatic push_disp(input string tag, input int base, input int v, input bit h12);
        int d, p;
        d = v;
        p = 0;
        if (h12) begin
            if (v == 0)       d = 12;
            else if (v == 12) p = 1;
            else if (v > 12) begin d = v - 12; p = 1; end
        end
        push({tag, ".tens"}, base + 3, d / 10);
        push({tag, ".ones"}, base + 4, d % 10);
        push({tag, ".pm"},   base + 5, p);
    endtask

    task automatic a_step(input string tag, input int exp_cnt, input int exp_carry, input int exp_lerr);
        push({tag, ".count"}, 0, exp_cnt);
        push({tag, ".carry"}, 1, exp_carry);
        push({tag, ".load_err"}, 2, exp_lerr);
        push_disp(tag, 0, prev_a, mode12);
        @(posedge clk);
        #1;
        check_all();
        prev_a   = exp_cnt;
        inc      = 1'b0;
        set_up   = 1'b0;
        set_dn   = 1'b0;
        load     = 1'b0;
        load_val = '0;
    endtask

    task automatic a_load(input string tag, input int v);
        load     = 1'b1;
        load_val = 5'(v);
        a_step(tag, v, 0, 0);
    endtask

    task automatic b_step(input string tag, input int exp_cnt, input int exp_carry);
        push({tag, ".count"}, 10, exp_cnt);
        push({tag, ".carry"}, 11, exp_carry);
        push({tag, ".load_err"}, 12, 0);
        push_disp(tag, 10, prev_b, 1'b0);
        @(posedge clk);
        #1;
        check_all();
        prev_b     = exp_cnt;
        b_inc      = 1'b0;
        b_set_up   = 1'b0;
        b_set_dn   = 1'b0;
        b_load     = 1'b0;
        b_load_val = '0;
    endtask

    initial begin
        rst = 1'b1;
        {inc, set_up, set_dn, load, mode12} = '0;
        load_val = '0;
        {b_inc, b_set_up, b_set_dn, b_load} = '0;
        b_load_val = '0;

        #3;
        push("rst.count", 0, 0);
        push("rst.carry", 1, 0);
        push("rst.load_err", 2, 0);
        push_disp("rst", 0, 0, 1'b0);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        a_step("idle0", 0, 0, 0);

        // Full 24-hour walk, wrap with carry, then a back-to-back inc.
        for (int i = 1; i <= 23; i++) begin
            inc = 1'b1;
            a_step($sformatf("inc%0d", i), i, 0, 0);
        end
        inc = 1'b1;
        a_step("wrap", 0, 1, 0);
        inc = 1'b1;
        a_step("b2b", 1, 0, 0);
        a_step("idle1", 1, 0, 0);

        // Out-of-range load is rejected and swallows a coincident inc.
        a_load("ld7", 7);
        load = 1'b1; load_val = 5'd25; inc = 1'b1;
        a_step("ld25", 7, 0, 1);
        load = 1'b1; load_val = 5'd17; inc = 1'b1;
        a_step("ld17inc", 17, 0, 0);
        a_step("idle2", 17, 0, 0);

        a_load("ld5a", 5);
        inc = 1'b1; set_dn = 1'b1;
        a_step("inc_dn", 6, 0, 0);
        a_load("ld5b", 5);
        set_up = 1'b1; set_dn = 1'b1;
        a_step("up_dn", 5, 0, 0);
        set_up = 1'b1;
        a_step("up", 6, 0, 0);
        set_dn = 1'b1;
        a_step("dn", 5, 0, 0);
        a_load("ld0", 0);
        set_dn = 1'b1;
        a_step("dn_wrap", 23, 0, 0);
        set_up = 1'b1;
        a_step("up_wrap", 0, 0, 0);
        load = 1'b1; load_val = 5'd23;
        a_step("ld23", 23, 0, 0);
        a_step("hold23", 23, 0, 0);

        mode12 = 1'b1;
        a_load("m12_0", 0);
        a_load("m12_11", 11);
        a_load("m12_12", 12);
        a_load("m12_13", 13);
        a_load("m12_23", 23);
        a_step("m12_idle", 23, 0, 0);
        mode12 = 1'b0;
        a_step("m24_idle", 23, 0, 0);

        // Asynchronous reset well before the next clock edge.
        a_load("ld14", 14);
        #2;
        rst = 1'b1;
        #1;
        push("arst.count", 0, 0);
        push("arst.carry", 1, 0);
        push("arst.load_err", 2, 0);
        push_disp("arst", 0, 0, 1'b0);
        check_all();
        @(negedge clk);
        rst    = 1'b0;
        prev_a = 0;
        prev_b = 0;
        a_step("post_rst", 0, 0, 0);

        // MAX=59 stage: adjust wraps both ways without carry; mode12 must be ignored.
        mode12     = 1'b1;
        b_load     = 1'b1;
        b_load_val = 6'd59;
        b_step("b_ld59", 59, 0);
        b_set_up = 1'b1;
        b_step("b_up_wrap", 0, 0);
        b_set_dn = 1'b1;
        b_step("b_dn_wrap", 59, 0);
        b_inc = 1'b1;
        b_step("b_inc_wrap", 0, 1);
        b_step("b_idle", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
